// File: rtl/mem_pkg.sv
// mem_pkg: shared response-owner encoding and default memory size for mem_arbiter
package mem_pkg;
  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} resp_t;
  localparam int MEM_SIZE_DEF = 16384;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between fetch and data, data-first with bounded fetch starvation
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_DEF,
  parameter int MAX_D_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(MAX_D_BURST + 1);
  localparam logic [31:0] ADDR_MAX = 32'(MEM_SIZE - 4);
  resp_t state;
  logic [CW-1:0] cnt;
  logic err_q, we_q, if_oor, d_oor;
  assign if_oor = if_addr > ADDR_MAX;
  assign d_oor = d_addr > ADDR_MAX;
  // grants are gated by rst_n so every output is quiet while reset is held
  always_comb begin
    if_gnt = rst_n & if_req & (!d_req | cnt == CW'(MAX_D_BURST));
    d_gnt = rst_n & d_req & !if_gnt;
    mem_en = (if_gnt & !if_oor) | (d_gnt & !d_oor);
    mem_we = d_gnt & d_we & !d_oor;
    mem_addr = if_gnt ? if_addr : d_gnt ? d_addr : '0;
    mem_wdata = (d_gnt & d_we & !d_oor) ? d_wdata : '0;
    if_rvalid = state == RESP_IF;
    if_err = if_rvalid & err_q;
    if_rdata = (if_rvalid & !err_q) ? mem_rdata : '0;
    d_rvalid = state == RESP_D;
    d_err = d_rvalid & err_q;
    d_rdata = (d_rvalid & !err_q & !we_q) ? mem_rdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      err_q <= 1'b0;
      we_q <= 1'b0;
    end else begin
      state <= if_gnt ? RESP_IF : d_gnt ? RESP_D : IDLE;
      err_q <= if_gnt ? if_oor : d_gnt & d_oor;
      we_q <= d_gnt & d_we;
      cnt <= (!if_req | if_gnt) ? '0 : d_gnt ? cnt + CW'(1) : cnt;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus response scoreboard against a behavioural memory
module tb_mem_arbiter;
  logic clk = 0, rst_n = 0;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  int total = 0, bad = 0;
  typedef struct {
    logic ir; logic [31:0] ia;
    logic dr, dw; logic [31:0] da, dd;
    logic eig, edg, eme;
  } vec_t;
  typedef struct packed {logic fetch, err; logic [31:0] data;} exp_t;
  exp_t q[$];
  vec_t tbl[12];
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr[13:2]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[13:2]];
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic check_resp();
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, e.fetch});
      chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, !e.fetch});
      chk("if_rdata", if_rdata, e.fetch ? e.data : 32'h0);
      chk("d_rdata", d_rdata, e.fetch ? 32'h0 : e.data);
      chk("if_err", {31'b0, if_err}, {31'b0, e.fetch & e.err});
      chk("d_err", {31'b0, d_err}, {31'b0, !e.fetch & e.err});
    end else
      chk("no_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'h0);
  endtask
  task automatic step(input vec_t v);
    exp_t e;
    logic [31:0] a;
    logic oor, st;
    @(negedge clk);
    check_resp();
    if_req = v.ir; if_addr = v.ia;
    d_req = v.dr; d_we = v.dw; d_addr = v.da; d_wdata = v.dd;
    #1;
    chk("if_gnt", {31'b0, if_gnt}, {31'b0, v.eig});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, v.edg});
    chk("mem_en", {31'b0, mem_en}, {31'b0, v.eme});
    if (v.eig | v.edg) begin
      a = v.eig ? v.ia : v.da;
      oor = a > 32'h3FFC;
      st = v.edg & v.dw;
      chk("mem_addr", mem_addr, a);
      chk("mem_we", {31'b0, mem_we}, {31'b0, st & !oor});
      if (st & !oor) chk("mem_wdata", mem_wdata, v.dd);
      e.fetch = v.eig;
      e.err = oor;
      e.data = (oor | st) ? 32'h0 : ref_mem[a[13:2]];
      if (st & !oor) ref_mem[a[13:2]] = v.dd;
      q.push_back(e);
    end
  endtask
  task automatic check_quiet(input string tag);
    chk({tag, "_gnt"}, {30'b0, if_gnt, d_gnt}, 32'h0);
    chk({tag, "_rvalid"}, {30'b0, if_rvalid, d_rvalid}, 32'h0);
    chk({tag, "_err"}, {30'b0, if_err, d_err}, 32'h0);
    chk({tag, "_mem_ctl"}, {30'b0, mem_en, mem_we}, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_rdata"}, if_rdata | d_rdata, 32'h0);
  endtask
  initial begin
    vec_t v;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'(i) * 32'h9E3779B1;
      ref_mem[i] = 32'(i) * 32'h9E3779B1;
    end
    mem[4] = 32'h00500093;
    ref_mem[4] = 32'h00500093;
    //          ir  ia           dr  dw  da           dd            eig edg eme
    tbl[0]  = '{0, 32'h0,      0, 0, 32'h0,      32'h0,        0, 0, 0};
    tbl[1]  = '{1, 32'h10,     0, 0, 32'h0,      32'h0,        1, 0, 1};
    tbl[2]  = '{1, 32'h20,     1, 0, 32'h100,    32'h0,        0, 1, 1};
    tbl[3]  = '{1, 32'h20,     0, 0, 32'h0,      32'h0,        1, 0, 1};
    tbl[4]  = '{0, 32'h0,      1, 1, 32'h200,    32'hDEADBEEF, 0, 1, 1};
    tbl[5]  = '{0, 32'h0,      1, 0, 32'h200,    32'h0,        0, 1, 1};
    tbl[6]  = '{0, 32'h0,      1, 0, 32'h3FFD,   32'h0,        0, 1, 0};
    tbl[7]  = '{1, 32'h4000,   0, 0, 32'h0,      32'h0,        1, 0, 0};
    tbl[8]  = '{0, 32'h0,      1, 1, 32'h3FFD,   32'h12345678, 0, 1, 0};
    tbl[9]  = '{0, 32'h0,      1, 0, 32'h3FFC,   32'h0,        0, 1, 1};
    tbl[10] = '{0, 32'h0,      1, 0, 32'h102,    32'h0,        0, 1, 1};
    tbl[11] = '{0, 32'h0,      0, 0, 32'h0,      32'h0,        0, 0, 0};
    if_req = 1; d_req = 1; d_we = 1; d_addr = 32'h40; if_addr = 32'h40; d_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check_quiet("reset_hold");
    @(negedge clk);
    if_req = 0; d_req = 0; d_we = 0;
    rst_n = 1;
    foreach (tbl[i]) step(tbl[i]);
    // fetch waits behind four data grants, then wins once
    for (int k = 0; k < 10; k++) begin
      v = '{k < 5, 32'h14, 1, 0, 32'h300 + 32'(4 * k), 32'h0, k == 4, k != 4, 1};
      step(v);
    end
    step(tbl[11]);
    step(tbl[11]);
    step(tbl[1]);
    @(posedge clk);
    #1;
    rst_n = 0;
    q.delete();
    if_req = 1; d_req = 1; d_we = 1;
    @(negedge clk);
    check_quiet("reset_mid");
    @(negedge clk);
    check_quiet("reset_mid2");
    if_req = 0; d_req = 0; d_we = 0;
    rst_n = 1;
    step(tbl[11]);
    step(tbl[11]);
    step(tbl[2]);
    step(tbl[11]);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 16384, memory size in bytes.
REQ-002 SHALL have parameter MAX_D_BURST, default 4, maximum consecutive data grants while a fetch waits.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port if_req  input  1  fetch request, held until granted.
REQ-006 SHALL have port if_addr  input  32  fetch byte address.
REQ-007 SHALL have port if_gnt  output  1  fetch accepted this cycle.
REQ-008 SHALL have port if_rvalid  output  1  fetch response valid.
REQ-009 SHALL have port if_rdata  output  32  fetched instruction word.
REQ-010 SHALL have port if_err  output  1  fetch address out of range, qualified by if_rvalid.
REQ-011 SHALL have port d_req  input  1  data request, held until granted.
REQ-012 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-013 SHALL have port d_addr  input  32  data byte address.
REQ-014 SHALL have port d_wdata  input  32  store data.
REQ-015 SHALL have port d_gnt  output  1  data request accepted this cycle.
REQ-016 SHALL have port d_rvalid  output  1  load data, or store acknowledge, valid.
REQ-017 SHALL have port d_rdata  output  32  load data.
REQ-018 SHALL have port d_err  output  1  data address out of range, qualified by d_rvalid.
REQ-019 SHALL have port mem_en  output  1  memory access strobe.
REQ-020 SHALL have port mem_we  output  1  memory write enable.
REQ-021 SHALL have port mem_addr  output  32  memory byte address.
REQ-022 SHALL have port mem_wdata  output  32  memory write data.
REQ-023 SHALL have port mem_rdata  input  32  memory read data, valid one cycle after mem_en.

Function
REQ-024 SHALL grant at most one requester per cycle; grant is combinational on the request; mem_en/mem_we/mem_addr/mem_wdata are driven from the granted requester in the same cycle.
REQ-025 SHALL drive if_rvalid or d_rvalid exactly one cycle after the matching grant; a new grant is allowed every cycle (fully pipelined, one outstanding response).
REQ-026 SHALL keep response-owner state {IDLE, RESP_IF, RESP_D}: a grant moves it to the owner's state, a cycle with no grant moves it to IDLE.
REQ-027 SHALL pass mem_rdata through to if_rdata in RESP_IF and to d_rdata in RESP_D (load only); otherwise both rdata outputs are 0.
REQ-028 SHALL give data priority over fetch when both request, except as in REQ-029.
REQ-029 SHALL count consecutive data grants made while if_req is high; when the count equals MAX_D_BURST, the next contended cycle grants fetch; the count clears on any fetch grant or on a cycle with if_req low.
REQ-030 SHALL treat an address > MEM_SIZE-4 as out of range: grant, keep mem_en low, then next cycle assert rvalid with err=1 and rdata=0; stores are dropped.
REQ-031 SHALL make a store's d_rvalid an acknowledge with d_rdata=0 and d_err=0 when in range.
REQ-032 SHALL pass addresses unaligned unchanged; no alignment check.

Reset
REQ-033 SHALL, while rst_n is low, hold state IDLE and burst count 0, with all gnt/rvalid/err/mem_en/mem_we outputs at 0 and all data/address outputs at 0.
REQ-034 SHALL discard any response in flight when reset is asserted mid-access; no rvalid follows reset release.

Structure
REQ-035 SHALL place the state encoding and the default MEM_SIZE constant in shared package mem_pkg.
REQ-036 SHALL be a single module with no sub-modules; the burst counter is sized $clog2(MAX_D_BURST+1).

Verification
REQ-037 SHALL verify fetch alone: if_req=1, if_addr=0x10, memory word 0x00500093 -> if_gnt same cycle, if_rvalid with if_rdata=0x00500093 next cycle.
REQ-038 SHALL verify contention: if_req and d_req both high for 1 cycle, d_we=0, d_addr=0x100 -> d_gnt=1, if_gnt=0; fetch granted the following cycle.
REQ-039 SHALL verify fairness: d_req held high for 10 cycles with if_req high -> the fetch is granted in cycle 5 (after 4 data grants).
REQ-040 SHALL verify a store: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, then a load from 0x200 -> d_rdata=0xDEADBEEF, d_err=0.
REQ-041 SHALL verify out of range: d_addr=0x3FFD (MEM_SIZE=16384) -> mem_en=0, next cycle d_rvalid=1, d_err=1, d_rdata=0.
REQ-042 SHALL verify reset: rst_n low in the cycle after a grant -> no rvalid, all outputs 0 until after release.
